// File: rtl/mem_init_loader.sv
// Byte-stream to dual-slot loader for data memory initialisation: packs bytes
// little-endian into 64-bit pairs and writes them at A and A+4 while holding the core.
`timescale 1ns/1ps
module mem_init_loader #(
  parameter int ADDR_W    = 12,
  parameter int MEM_BYTES = 4096,
  parameter int CNT_W     = 13
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_datain1,
  output logic [31:0]       mem_datain2,
  output logic [3:0]        mem_wr,
  output logic              mem_load_en,
  output logic              core_hold,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  logic [63:0]       pack_buf;
  logic [63:0]       pack_next;
  logic [2:0]        idx;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] addr_q;
  logic              accept;

  // Pair address advance, wrapping modulo the memory size.
  function automatic logic [ADDR_W-1:0] wrap_add8(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] sum;
    sum = {1'b0, a} + (ADDR_W+1)'(8);
    if (sum >= (ADDR_W+1)'(MEM_BYTES))
      sum = sum - (ADDR_W+1)'(MEM_BYTES);
    return sum[ADDR_W-1:0];
  endfunction

  // byte_ready is registered and only high in COLLECT, so this is the handshake.
  assign accept = byte_valid & byte_ready;

  always_comb begin
    pack_next = pack_buf;
    pack_next[{idx, 3'b000} +: 8] = byte_in;
  end

  assign core_hold = busy;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      pack_buf    <= '0;
      idx         <= '0;
      remaining   <= '0;
      addr_q      <= '0;
      byte_ready  <= 1'b0;
      mem_address <= '0;
      mem_datain1 <= '0;
      mem_datain2 <= '0;
      mem_wr      <= '0;
      mem_load_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      mem_load_en <= 1'b0;
      mem_wr      <= '0;
      mem_address <= '0;
      mem_datain1 <= '0;
      mem_datain2 <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (byte_count != '0) begin
              addr_q     <= base_addr;
              remaining  <= byte_count;
              byte_ready <= 1'b1;
              state      <= COLLECT;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            pack_buf  <= pack_next;
            idx       <= idx + 3'd1;
            remaining <= remaining - CNT_W'(1);
            // Last lane or last byte: present the pair in the very next cycle.
            if (idx == 3'd7 || remaining == CNT_W'(1)) begin
              byte_ready  <= 1'b0;
              mem_load_en <= 1'b1;
              mem_wr      <= 4'hF;
              mem_address <= addr_q;
              mem_datain1 <= pack_next[31:0];
              mem_datain2 <= pack_next[63:32];
              state       <= WRITE;
            end
          end
        end
        WRITE: begin
          addr_q   <= wrap_add8(addr_q);
          pack_buf <= '0;
          idx      <= '0;
          if (remaining == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            byte_ready <= 1'b1;
            state      <= COLLECT;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_init_loader.sv
// Directed bench for mem_init_loader: hand-computed write records, cycle positions and reset abort.
`timescale 1ns/1ps
module tb_mem_init_loader;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] byte_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [11:0] mem_address;
  logic [31:0] mem_datain1;
  logic [31:0] mem_datain2;
  logic [3:0]  mem_wr;
  logic        mem_load_en;
  logic        core_hold;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [11:0] wr_addr [4];
  logic [31:0] wr_d1   [4];
  logic [31:0] wr_d2   [4];
  logic [3:0]  wr_we   [4];
  int          wr_cyc  [4];
  int          nwr, ndone, done_cyc, last_acc;
  bit          busy_ok;

  mem_init_loader #(.ADDR_W(12), .MEM_BYTES(4096), .CNT_W(13)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .base_addr(base_addr),
    .byte_count(byte_count), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_address(mem_address),
    .mem_datain1(mem_datain1), .mem_datain2(mem_datain2), .mem_wr(mem_wr),
    .mem_load_en(mem_load_en), .core_hold(core_hold), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Runs one load; cycle 0 is the start cycle. Records writes and the done pulse.
  task automatic run_load(input logic [11:0] base, input logic [12:0] cnt,
                          input logic [7:0] first, input bit toggle, input bit mid_start);
    int  k;
    int  cyc;
    bit  hs;
    bit  finished;
    bit  pulsed;
    k = 0; cyc = 0; finished = 0; pulsed = 0;
    nwr = 0; ndone = 0; done_cyc = -1; last_acc = -1; busy_ok = 1;
    while (!finished && cyc < 400) begin
      if (cyc == 0) begin
        start = 1'b1; base_addr = base; byte_count = cnt;
      end else if (mid_start && k == 3 && !pulsed) begin
        start = 1'b1; base_addr = 12'h123; byte_count = 13'd5; pulsed = 1;
      end else begin
        start = 1'b0;
      end
      byte_valid = (k < int'(cnt)) && (cyc > 0) && (!toggle || cyc[0]);
      byte_in    = first + 8'(k);
      hs = byte_valid && byte_ready;
      tick();
      if (hs) begin
        k++;
        last_acc = cyc;
      end
      cyc++;
      if (!(busy && core_hold)) busy_ok = 0;
      if (mem_load_en && nwr < 4) begin
        wr_addr[nwr] = mem_address; wr_d1[nwr] = mem_datain1;
        wr_d2[nwr] = mem_datain2; wr_we[nwr] = mem_wr; wr_cyc[nwr] = cyc;
        nwr++;
      end
      if (done) begin
        ndone++; finished = 1; done_cyc = cyc;
      end
    end
    start = 1'b0; byte_valid = 1'b0;
    if (!finished) chk("timeout", 64'd0, 64'd1);
    tick();
    chk("idle_after_done", {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    bit seen;
    Rst = 1'b1; start = 1'b0; base_addr = '0; byte_count = '0;
    byte_in = '0; byte_valid = 1'b0;
    tick(); tick();
    chk("rst_ctrl", {busy, core_hold, done, byte_ready, mem_load_en, mem_wr}, 64'd0);
    chk("rst_addr", {52'd0, mem_address}, 64'd0);
    chk("rst_data", {mem_datain1, mem_datain2}, 64'd0);
    Rst = 1'b0;
    tick();

    // count=8, continuous valid
    run_load(12'h000, 13'd8, 8'h01, 0, 0);
    chk("t1_nwr", 64'(nwr), 64'd1);
    chk("t1_addr", {52'd0, wr_addr[0]}, 64'h000);
    chk("t1_data", {wr_d1[0], wr_d2[0]}, 64'h04030201_08070605);
    chk("t1_we", {60'd0, wr_we[0]}, 64'hF);
    chk("t1_wr_cyc", 64'(wr_cyc[0]), 64'd9);
    chk("t1_done_cyc", 64'(done_cyc), 64'd10);
    chk("t1_busy", {63'd0, busy_ok}, 64'd1);

    // count=11 from 0x100: a full pair then a zero-padded partial pair
    run_load(12'h100, 13'd11, 8'hA0, 0, 0);
    chk("t2_nwr", 64'(nwr), 64'd2);
    chk("t2_addr0", {52'd0, wr_addr[0]}, 64'h100);
    chk("t2_data0", {wr_d1[0], wr_d2[0]}, 64'hA3A2A1A0_A7A6A5A4);
    chk("t2_addr1", {52'd0, wr_addr[1]}, 64'h108);
    chk("t2_data1", {wr_d1[1], wr_d2[1]}, 64'h00AAA9A8_00000000);
    chk("t2_wr_cyc1", 64'(wr_cyc[1]), 64'd13);
    chk("t2_done_cyc", 64'(done_cyc), 64'd14);

    // valid toggling every cycle
    run_load(12'h000, 13'd8, 8'h01, 1, 0);
    chk("t3_nwr", 64'(nwr), 64'd1);
    chk("t3_data", {wr_d1[0], wr_d2[0]}, 64'h04030201_08070605);
    chk("t3_last_acc", 64'(last_acc), 64'd15);
    chk("t3_wr_after_acc", 64'(wr_cyc[0]), 64'(last_acc + 1));

    // address wrap with a stray start mid-transfer
    run_load(12'hFF8, 13'd16, 8'h10, 0, 1);
    chk("t4_nwr", 64'(nwr), 64'd2);
    chk("t4_addr0", {52'd0, wr_addr[0]}, 64'hFF8);
    chk("t4_data0", {wr_d1[0], wr_d2[0]}, 64'h13121110_17161514);
    chk("t4_addr1", {52'd0, wr_addr[1]}, 64'h000);
    chk("t4_data1", {wr_d1[1], wr_d2[1]}, 64'h1B1A1918_1F1E1D1C);
    chk("t4_done_cyc", 64'(done_cyc), 64'd19);

    // count=0: no write, done one cycle after start
    run_load(12'h300, 13'd0, 8'h55, 0, 0);
    chk("t5_nwr", 64'(nwr), 64'd0);
    chk("t5_done_cyc", 64'(done_cyc), 64'd1);

    // reset after 5 of 8 bytes
    start = 1'b1; base_addr = 12'h200; byte_count = 13'd8;
    tick();
    start = 1'b0; byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      byte_in = 8'hE0 + 8'(i);
      tick();
    end
    byte_valid = 1'b0; Rst = 1'b1;
    tick();
    chk("t6_rst_ctrl", {busy, core_hold, done, byte_ready, mem_load_en, mem_wr}, 64'd0);
    chk("t6_rst_out", {mem_address, mem_datain1, mem_datain2}, 76'd0);
    Rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_load_en || done || busy) seen = 1;
    end
    chk("t6_quiet", {63'd0, seen}, 64'd0);
    run_load(12'h040, 13'd8, 8'hC0, 0, 0);
    chk("t6_nwr", 64'(nwr), 64'd1);
    chk("t6_addr", {52'd0, wr_addr[0]}, 64'h040);
    chk("t6_data", {wr_d1[0], wr_d2[0]}, 64'hC3C2C1C0_C7C6C5C4);
    chk("t6_wr_cyc", 64'(wr_cyc[0]), 64'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_init_loader.md
Name: mem_init_loader

Overview:
- Upstream feeder for the data memory's initialisation path.
- Accepts a byte stream over a valid/ready handshake from the debug/host link and packs it little-endian into 64-bit pairs.
- Drives the data memory in dual-slot load mode, writing two 32-bit words per write cycle at address A and A+4.
- Holds the core pipeline for the whole transfer.

Parameters:
- ADDR_W, 12, byte address width of the data memory.
- MEM_BYTES, 4096, data memory size in bytes; address arithmetic wraps modulo this value.
- CNT_W, 13, width of byte_count; must hold the value MEM_BYTES.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first byte address; any alignment allowed; latched on an accepted start.
- byte_count  in  CNT_W  number of bytes to load, 0..MEM_BYTES; latched on an accepted start.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader can accept a byte; a transfer occurs when byte_valid & byte_ready.
- mem_address  out  ADDR_W  write address to the data memory (second word goes to mem_address+4).
- mem_datain1  out  32  word for mem_address.
- mem_datain2  out  32  word for mem_address+4.
- mem_wr  out  4  byte write enables, active-high at this interface.
- mem_load_en  out  1  selects the memory's dual-slot load mode.
- core_hold  out  1  stalls the pipeline; the memory clock-gate halt must remain 0 while this block writes.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a load completes.

Behaviour:
- Reset values: all outputs 0. State IDLE. Pack buffer, index, remaining-byte counter and address register cleared.
- Reset mid-transfer: abort immediately, return to IDLE, discard the partial buffer, perform no write, emit no done.
- State IDLE:
  - byte_ready=0.
  - start with byte_count!=0 -> latch base_addr and byte_count, go to COLLECT.
  - start with byte_count==0 -> go to DONE; no write is issued.
- State COLLECT:
  - byte_ready=1.
  - Each accepted byte is written to buffer byte lane idx (idx 0..7), then idx increments and remaining decrements.
  - Lanes 0-3 form mem_datain1[7:0]..[31:24]; lanes 4-7 form mem_datain2[7:0]..[31:24].
  - On acceptance with idx==7, or with remaining==1, go to WRITE on the next edge.
  - A cycle without a transfer changes nothing; there is no timeout.
- State WRITE (exactly one cycle):
  - byte_ready=0, mem_load_en=1, mem_wr=4'hF.
  - mem_address = address register; mem_datain1/2 = buffer contents.
  - Unfilled lanes of a final partial pair are 0 and are still written; full 8 bytes are written every time.
  - On exit: address += 8 modulo MEM_BYTES, buffer and idx cleared.
  - Next state is DONE if remaining==0, else COLLECT.
- State DONE: done=1 for one cycle, then IDLE.
- Outside WRITE: mem_load_en=0, mem_wr=0, mem_address=0, mem_datain1=0, mem_datain2=0.
- core_hold=busy.
- start while busy is ignored.
- byte_valid while in IDLE, WRITE or DONE is not acknowledged.
- Latency with continuous valid: start accepted at cycle 0; COLLECT accepts 8 bytes in cycles 1-8; WRITE in cycle 9. Each further pair costs 9 cycles. DONE follows the last WRITE.
- Address wrap: base 0xFF8 -> first write at 0xFF8, second write at 0x000.
- Words that straddle the wrap (for example mem_address 0xFFC, second word at 0x000) follow the memory's modulo addressing; this block adds no extra handling.
- All outputs come from registered state; no combinational path from byte_valid to any mem_* output.

Test Plan:
- Reset, then start with base=0x000, count=8, bytes 0x01..0x08 with continuous valid -> exactly one WRITE at cycle 9:
  - mem_address=0x000, mem_datain1=0x04030201, mem_datain2=0x08070605, mem_wr=4'hF, mem_load_en=1.
  - done pulses at cycle 10; busy and core_hold are high in cycles 1-10.
- count=11 from base=0x100, bytes 0xA0..0xAA -> two writes:
  - first at 0x100: datain1=0xA3A2A1A0, datain2=0xA7A6A5A4.
  - second at 0x108: datain1=0xAAA9A8, datain2=0x00000000.
  - done follows the second write.
- byte_valid toggled 1/0 every cycle with count=8 -> 8 bytes are accepted only on valid&ready cycles; the data matches the continuous-valid case; WRITE occurs the cycle after the 8th acceptance.
- base=0xFF8, count=16 -> writes at 0xFF8 and then 0x000; start pulsed mid-transfer is ignored with no state change.
- count=0 -> no WRITE; done pulses one cycle after start.
- Rst asserted after 5 of 8 bytes are accepted -> next cycle IDLE, all outputs 0, no write, no done. A following start with count=8 loads cleanly from lane 0.
